// File: rtl/pipeline_scoreboard_pkg.sv
// Shared types for the pipeline scoreboard: tracked-entry layout, id/select widths and helpers.
package pipeline_scoreboard_pkg;

  // Default configuration; entry fields are sized from these.
  localparam int unsigned REG_COUNT_DEFAULT   = 32;
  localparam int unsigned MAX_LATENCY_DEFAULT = 1;
  localparam int unsigned TRACK_DEPTH_DEFAULT = 3;

  localparam int unsigned RID_W = $clog2(REG_COUNT_DEFAULT);
  localparam int unsigned LAT_W = (MAX_LATENCY_DEFAULT > 0) ? $clog2(MAX_LATENCY_DEFAULT + 1) : 1;
  localparam int unsigned SEL_W = $clog2(TRACK_DEPTH_DEFAULT + 1);

  typedef logic [RID_W-1:0] reg_id_t;
  typedef logic [LAT_W-1:0] latency_t;
  typedef logic [SEL_W-1:0] forward_select_t;

  typedef struct packed {
    logic     valid;
    logic     writeEnabled;
    reg_id_t  writeId;
    latency_t remaining;  // stages still to go before the result appears on an output
  } scoreboard_entry_t;

  localparam forward_select_t FORWARD_REGFILE = '0;

  // Remaining-latency countdown, held at zero once the result is available.
  function automatic latency_t decSat(latency_t r);
    return (r == '0) ? r : r - latency_t'(1);
  endfunction

endpackage

// File: rtl/scoreboard_lookup.sv
// Per-read-port search of the tracked entries: youngest matching writer decides forward or stall.
module scoreboard_lookup
  import pipeline_scoreboard_pkg::*;
#(
  parameter int unsigned TRACK_DEPTH = 3,
  parameter int unsigned SEL_W_P     = 2
) (
  input  scoreboard_entry_t [TRACK_DEPTH-1:0] entries,
  input  logic                                readUsed,
  input  reg_id_t                             readId,
  output logic                                hazard,
  output logic [SEL_W_P-1:0]                  select
);

  logic found;

  // Priority search from entry 0 (youngest); first match wins, r0 and unused ports never match.
  always_comb begin
    hazard = 1'b0;
    select = SEL_W_P'(FORWARD_REGFILE);
    found  = 1'b0;
    if (readUsed && (readId != '0)) begin
      for (int i = 0; i < TRACK_DEPTH; i++) begin
        if (!found && entries[i].valid && entries[i].writeEnabled &&
            (entries[i].writeId == readId)) begin
          found = 1'b1;
          if (entries[i].remaining == '0) begin
            select = SEL_W_P'(i + 1);
          end else begin
            hazard = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/pipeline_scoreboard.sv
// Hazard/forwarding controller: tracks in-flight writers from execute to writeback, selects
// forward sources per read port, stalls decode on unready producers, counts stalls and bubbles.
module pipeline_scoreboard
  import pipeline_scoreboard_pkg::*;
#(
  parameter int unsigned TRACK_DEPTH    = TRACK_DEPTH_DEFAULT,
  parameter int unsigned NUM_READ_PORTS = 2,
  parameter int unsigned REG_COUNT      = REG_COUNT_DEFAULT,
  parameter int unsigned MAX_LATENCY    = MAX_LATENCY_DEFAULT,
  parameter int unsigned COUNTER_WIDTH  = 32,
  localparam int unsigned ReadIdWidth   = $clog2(REG_COUNT),
  localparam int unsigned LatencyWidth  = (MAX_LATENCY > 0) ? $clog2(MAX_LATENCY + 1) : 1,
  localparam int unsigned SelectWidth   = $clog2(TRACK_DEPTH + 1)
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  issueValid,
  input  logic [NUM_READ_PORTS*ReadIdWidth-1:0] issueReadId,
  input  logic [NUM_READ_PORTS-1:0]             issueReadUsed,
  input  logic                                  issueWriteEnabled,
  input  logic [ReadIdWidth-1:0]                issueWriteId,
  input  logic [LatencyWidth-1:0]               issueLatency,
  input  logic                                  backStall,
  input  logic                                  jumpEnabled,
  output logic                                  issueAccepted,
  output logic                                  stallOnDecode,
  output logic [NUM_READ_PORTS*SelectWidth-1:0] forwardSelect,
  output logic [TRACK_DEPTH-1:0]                stageValid,
  output logic [COUNTER_WIDTH-1:0]              stallCount,
  output logic [COUNTER_WIDTH-1:0]              bubbleCount
);

  scoreboard_entry_t [TRACK_DEPTH-1:0] entryQ, entryD;
  logic [COUNTER_WIDTH-1:0]            stallCountQ, stallCountD;
  logic [COUNTER_WIDTH-1:0]            bubbleCountQ, bubbleCountD;
  logic [NUM_READ_PORTS-1:0]           hazard;
  logic [NUM_READ_PORTS*SelectWidth-1:0] lookupSelect;
  logic                                rawStall, rawAccept;

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : gen_lookup
    scoreboard_lookup #(
      .TRACK_DEPTH (TRACK_DEPTH),
      .SEL_W_P     (SelectWidth)
    ) u_lookup (
      .entries  (entryQ),
      .readUsed (issueReadUsed[p]),
      .readId   (reg_id_t'(issueReadId[p*ReadIdWidth +: ReadIdWidth])),
      .hazard   (hazard[p]),
      .select   (lookupSelect[p*SelectWidth +: SelectWidth])
    );
  end

  // Issue decision; outputs forced low while reset is asserted, since inputs may still toggle.
  always_comb begin
    rawStall      = issueValid & ((|hazard) | backStall) & ~jumpEnabled;
    rawAccept     = issueValid & ~rawStall & ~jumpEnabled & ~backStall;
    stallOnDecode = reset & rawStall;
    issueAccepted = reset & rawAccept;
    forwardSelect = reset ? lookupSelect : '0;
    for (int i = 0; i < TRACK_DEPTH; i++) begin
      stageValid[i] = entryQ[i].valid;
    end
    stallCount  = stallCountQ;
    bubbleCount = bubbleCountQ;
  end

  // Entry shift: advance unless the back end is frozen; entry 0 takes the issued op or a bubble.
  always_comb begin
    entryD = entryQ;
    if (!backStall) begin
      if (rawAccept) begin
        entryD[0] = '{valid:        1'b1,
                      writeEnabled: issueWriteEnabled,
                      writeId:      reg_id_t'(issueWriteId),
                      remaining:    latency_t'(issueLatency)};
      end else begin
        entryD[0] = '0;
      end
      for (int i = 1; i < TRACK_DEPTH; i++) begin
        entryD[i]           = entryQ[i-1];
        entryD[i].remaining = decSat(entryQ[i-1].remaining);
      end
    end
  end

  // Saturating performance counters.
  always_comb begin
    stallCountD  = stallCountQ;
    bubbleCountD = bubbleCountQ;
    if (rawStall && (stallCountQ != '1)) begin
      stallCountD = stallCountQ + COUNTER_WIDTH'(1);
    end
    if (!backStall && !rawAccept && (bubbleCountQ != '1)) begin
      bubbleCountD = bubbleCountQ + COUNTER_WIDTH'(1);
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      entryQ       <= '0;
      stallCountQ  <= '0;
      bubbleCountQ <= '0;
    end else begin
      entryQ       <= entryD;
      stallCountQ  <= stallCountD;
      bubbleCountQ <= bubbleCountD;
    end
  end

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Self-checking bench for pipeline_scoreboard: directed hazard scenarios then random traffic,
// compared against a position-based model of in-flight writers.
module tb_pipeline_scoreboard;

  localparam int TD = 3;
  localparam int NP = 2;
  localparam int RW = 5;
  localparam int SW = 2;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          issueValid;
  logic [NP*RW-1:0] issueReadId;
  logic [NP-1:0] issueReadUsed;
  logic          issueWriteEnabled;
  logic [RW-1:0] issueWriteId;
  logic [0:0]    issueLatency;
  logic          backStall;
  logic          jumpEnabled;
  logic          issueAccepted;
  logic          stallOnDecode;
  logic [NP*SW-1:0] forwardSelect;
  logic [TD-1:0] stageValid;
  logic [CW-1:0] stallCount;
  logic [CW-1:0] bubbleCount;

  pipeline_scoreboard #(
    .TRACK_DEPTH    (TD),
    .NUM_READ_PORTS (NP),
    .REG_COUNT      (32),
    .MAX_LATENCY    (1),
    .COUNTER_WIDTH  (CW)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .issueValid        (issueValid),
    .issueReadId       (issueReadId),
    .issueReadUsed     (issueReadUsed),
    .issueWriteEnabled (issueWriteEnabled),
    .issueWriteId      (issueWriteId),
    .issueLatency      (issueLatency),
    .backStall         (backStall),
    .jumpEnabled       (jumpEnabled),
    .issueAccepted     (issueAccepted),
    .stallOnDecode     (stallOnDecode),
    .forwardSelect     (forwardSelect),
    .stageValid        (stageValid),
    .stallCount        (stallCount),
    .bubbleCount       (bubbleCount)
  );

  always #5 clock = ~clock;

  int testsRun = 0;
  int testsFailed = 0;
  int cycle = 0;

  // Model: slot k holds the writer that has advanced k times since issue.
  bit mValid[TD];
  bit mWe[TD];
  int mId[TD];
  int mLat[TD];
  int mStall, mBubble;
  int expSel[NP];
  bit expStall, expAcc;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s (cycle %0d): got %0d expected %0d", tag, cycle, got, exp);
    end
  endtask

  task automatic modelClear();
    for (int i = 0; i < TD; i++) begin
      mValid[i] = 1'b0; mWe[i] = 1'b0; mId[i] = 0; mLat[i] = 0;
    end
    mStall = 0;
    mBubble = 0;
  endtask

  task automatic drive(input bit v, input bit we, input int wid, input int lat, input bit [1:0] used,
                       input int id0, input int id1, input bit bs, input bit j);
    issueValid        = v;
    issueWriteEnabled = we;
    issueWriteId      = RW'(wid);
    issueLatency      = 1'(lat);
    issueReadUsed     = used;
    issueReadId       = {RW'(id1), RW'(id0)};
    backStall         = bs;
    jumpEnabled       = j;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
  endtask

  // Compute expected outputs from the model and compare; called just after a falling edge.
  task automatic evalCheck();
    bit anyHaz;
    int ids[NP];
    logic [TD-1:0] expValid;
    #1;
    if (!reset) modelClear();
    ids[0] = int'(issueReadId[RW-1:0]);
    ids[1] = int'(issueReadId[2*RW-1:RW]);
    anyHaz = 1'b0;
    for (int p = 0; p < NP; p++) begin
      expSel[p] = 0;
      if (issueReadUsed[p] && ids[p] != 0) begin
        for (int i = 0; i < TD; i++) begin
          if (mValid[i] && mWe[i] && mId[i] == ids[p]) begin
            if (mLat[i] > i) anyHaz = 1'b1;
            else expSel[p] = i + 1;
            break;
          end
        end
      end
    end
    expStall = issueValid && (anyHaz || backStall) && !jumpEnabled;
    expAcc   = issueValid && !expStall && !jumpEnabled && !backStall;
    for (int i = 0; i < TD; i++) expValid[i] = mValid[i];
    checkValue("issueAccepted", 32'(issueAccepted), reset ? 32'(expAcc) : 32'd0);
    checkValue("stallOnDecode", 32'(stallOnDecode), reset ? 32'(expStall) : 32'd0);
    for (int p = 0; p < NP; p++)
      checkValue("forwardSelect", 32'(forwardSelect[p*SW +: SW]), reset ? 32'(expSel[p]) : 32'd0);
    checkValue("stageValid", 32'(stageValid), 32'(expValid));
    checkValue("stallCount", 32'(stallCount), 32'(mStall));
    checkValue("bubbleCount", 32'(bubbleCount), 32'(mBubble));
  endtask

  task automatic advanceClock();
    @(posedge clock);
    if (reset) begin
      if (!backStall) begin
        for (int i = TD - 1; i > 0; i--) begin
          mValid[i] = mValid[i-1]; mWe[i] = mWe[i-1]; mId[i] = mId[i-1]; mLat[i] = mLat[i-1];
        end
        mValid[0] = expAcc;
        mWe[0]    = issueWriteEnabled;
        mId[0]    = int'(issueWriteId);
        mLat[0]   = int'(issueLatency);
        if (!expAcc && mBubble < CMAX) mBubble++;
      end
      if (expStall && mStall < CMAX) mStall++;
    end
    @(negedge clock);
    cycle++;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    modelClear();
    @(negedge clock);

    // Reset state.
    evalCheck();
    checkValue("reset_stageValid", 32'(stageValid), 32'd0);
    advanceClock();
    evalCheck();
    advanceClock();
    reset = 1'b1;
    idle();
    evalCheck();
    advanceClock();

    // Load-use: lat1 producer forces exactly one stall, then forward from memory output.
    drive(1, 1, 3, 1, 2'b00, 0, 0, 0, 0);
    evalCheck();
    checkValue("lu_issue", 32'(issueAccepted), 32'd1);
    advanceClock();
    drive(1, 0, 0, 0, 2'b01, 3, 0, 0, 0);
    evalCheck();
    checkValue("lu_stall", 32'(stallOnDecode), 32'd1);
    checkValue("lu_noaccept", 32'(issueAccepted), 32'd0);
    advanceClock();
    evalCheck();
    checkValue("lu_release", 32'(stallOnDecode), 32'd0);
    checkValue("lu_select", 32'(forwardSelect[SW-1:0]), 32'd2);
    checkValue("lu_stallCount", 32'(stallCount), 32'd1);
    advanceClock();

    // ALU chain: lat0 producer forwards from execute output next cycle.
    drive(1, 1, 5, 0, 2'b00, 0, 0, 0, 0);
    evalCheck();
    advanceClock();
    drive(1, 0, 0, 0, 2'b01, 5, 0, 0, 0);
    evalCheck();
    checkValue("alu_select", 32'(forwardSelect[SW-1:0]), 32'd1);
    checkValue("alu_nostall", 32'(stallOnDecode), 32'd0);
    checkValue("alu_accept", 32'(issueAccepted), 32'd1);
    advanceClock();

    // r0 never forwards; an unused port is ignored even when its id has a pending writer.
    drive(1, 1, 0, 0, 2'b00, 0, 0, 0, 0);
    evalCheck();
    advanceClock();
    drive(1, 1, 9, 1, 2'b00, 0, 0, 0, 0);
    evalCheck();
    advanceClock();
    drive(1, 0, 0, 0, 2'b01, 0, 9, 0, 0);
    evalCheck();
    checkValue("r0_select", 32'(forwardSelect[SW-1:0]), 32'd0);
    checkValue("unused_select", 32'(forwardSelect[2*SW-1:SW]), 32'd0);
    checkValue("r0_nostall", 32'(stallOnDecode), 32'd0);
    advanceClock();

    // Jump squashes the issuing instruction into a bubble.
    drive(1, 1, 4, 0, 2'b00, 0, 0, 0, 1);
    evalCheck();
    checkValue("jump_noaccept", 32'(issueAccepted), 32'd0);
    advanceClock();
    idle();
    evalCheck();
    checkValue("jump_bubble", 32'(stageValid[0]), 32'd0);
    advanceClock();

    // Youngest writer wins; backStall holds all entries.
    drive(1, 1, 7, 0, 2'b00, 0, 0, 0, 0);
    evalCheck();
    advanceClock();
    drive(1, 1, 8, 0, 2'b00, 0, 0, 0, 0);
    evalCheck();
    advanceClock();
    drive(1, 1, 7, 0, 2'b00, 0, 0, 0, 0);
    evalCheck();
    advanceClock();
    drive(1, 0, 0, 0, 2'b01, 7, 0, 1, 0);
    for (int k = 0; k < 2; k++) begin
      evalCheck();
      checkValue("young_select", 32'(forwardSelect[SW-1:0]), 32'd1);
      checkValue("hold_valid", 32'(stageValid), 32'd7);
      advanceClock();
    end

    // Reset mid-stall with all entries valid.
    reset = 1'b0;
    evalCheck();
    checkValue("midreset_valid", 32'(stageValid), 32'd0);
    checkValue("midreset_stall", 32'(stallOnDecode), 32'd0);
    checkValue("midreset_stallCount", 32'(stallCount), 32'd0);
    advanceClock();
    reset = 1'b1;
    idle();
    evalCheck();
    checkValue("postreset_valid", 32'(stageValid), 32'd0);
    advanceClock();

    // Random traffic, including occasional resets and saturation of the narrow counters.
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 63) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
            $urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
      evalCheck();
      advanceClock();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
